// File: rtl/seg7_scan_scheduler_pkg.sv
// Shared definitions for the 4-digit 7-segment scan scheduler: FSM encoding,
// blanking constants and the active-low hex segment table.
package seg7_scan_scheduler_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // {A,B,C,D,E,F,G}, active-low, indexed by hex value
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

endpackage

// File: rtl/seg7_scan_scheduler_hex_to_seg7.sv
// Combinational hex digit to active-low 7-segment pattern decoder.
module seg7_scan_scheduler_hex_to_seg7
    import seg7_scan_scheduler_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_hex];

endmodule

// File: rtl/seg7_scan_scheduler.sv
// Scans a frame-stable copy of four hex digits onto a common-anode display with
// a blanking gap before each digit; new values commit only at frame boundaries.
module seg7_scan_scheduler
    import seg7_scan_scheduler_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic        clk_i,
    input  logic        reset,
    input  logic [15:0] digits_i,
    input  logic        load_i,
    input  logic        lz_en_i,
    output logic        load_ack_o,
    output logic        frame_o,
    output logic [6:0]  seg_o,
    output logic [3:0]  an_o
);

    localparam int unsigned      CNT_W      = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_slot_cnt;
    logic [CNT_W-1:0] w_slot_cnt_next;
    logic [1:0]       r_idx;
    logic [1:0]       w_idx_next;

    logic [15:0]      r_active;
    logic [15:0]      w_active_next;
    logic [15:0]      r_staged;
    logic             r_pending;
    logic             r_ack;

    logic [6:0]       r_seg;
    logic [3:0]       r_an;
    logic [6:0]       w_seg_next;
    logic [3:0]       w_an_next;

    logic             w_slot_end;
    logic             w_frame;
    logic             w_commit;
    logic [3:0]       w_digit;
    logic [6:0]       w_seg_dec;
    logic [3:0]       w_lz_blank;

    assign w_slot_end = (r_slot_cnt == CNT_LAST);
    assign w_frame    = (r_idx == 2'd3) && w_slot_end;
    assign w_commit   = w_frame && r_pending;

    // ---------------------------------------------------------------- FSM state register
    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_state    <= ST_BLANK;
            r_slot_cnt <= '0;
            r_idx      <= 2'd0;
        end else begin
            r_state    <= w_state_next;
            r_slot_cnt <= w_slot_cnt_next;
            r_idx      <= w_idx_next;
        end
    end

    // ---------------------------------------------------------------- FSM next state
    always_comb begin
        w_state_next    = r_state;
        w_slot_cnt_next = w_slot_end ? '0 : r_slot_cnt + 1'b1;
        w_idx_next      = r_idx;
        case (r_state)
            ST_BLANK: begin
                if (r_slot_cnt == BLANK_LAST) begin
                    w_state_next = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (w_slot_end) begin
                    w_state_next = ST_BLANK;
                    w_idx_next   = r_idx + 2'd1;
                end
            end
            default: w_state_next = ST_BLANK;
        endcase
    end

    // ---------------------------------------------------------------- stage / commit
    assign w_active_next = w_commit ? r_staged : r_active;

    // A load in the frame cycle lands in staged after the commit has read the old value.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_active  <= 16'h0000;
            r_staged  <= 16'h0000;
            r_pending <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_active <= w_active_next;
            r_ack    <= w_commit;
            if (load_i) begin
                r_staged  <= digits_i;
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- digit select / decode
    always_comb begin
        w_digit = w_active_next[3:0];
        case (w_idx_next)
            2'd0: w_digit = w_active_next[3:0];
            2'd1: w_digit = w_active_next[7:4];
            2'd2: w_digit = w_active_next[11:8];
            2'd3: w_digit = w_active_next[15:12];
            default: w_digit = w_active_next[3:0];
        endcase
    end

    seg7_scan_scheduler_hex_to_seg7 u_hex_to_seg7 (
        .i_hex (w_digit),
        .o_seg (w_seg_dec)
    );

    // A digit is blanked when it and every higher digit are zero; digit 0 always shows.
    always_comb begin
        w_lz_blank[3] = lz_en_i && (w_active_next[15:12] == 4'h0);
        w_lz_blank[2] = lz_en_i && (w_active_next[15:8] == 8'h00);
        w_lz_blank[1] = lz_en_i && (w_active_next[15:4] == 12'h000);
        w_lz_blank[0] = 1'b0;
    end

    // ---------------------------------------------------------------- FSM outputs
    // Driven from next-state values so the pins move on the same edge as the state.
    always_comb begin
        w_an_next  = AN_OFF;
        w_seg_next = SEG_OFF;
        if (w_state_next == ST_SHOW) begin
            w_an_next = ~(4'b0001 << w_idx_next);
            if (!w_lz_blank[w_idx_next]) begin
                w_seg_next = w_seg_dec;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_seg <= SEG_OFF;
            r_an  <= AN_OFF;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
        end
    end

    assign seg_o      = r_seg;
    assign an_o       = r_an;
    assign load_ack_o = r_ack;
    assign frame_o    = w_frame;

endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// Self-checking bench for seg7_scan_scheduler with SCAN_DIV=8, BLANK_CYC=2.
module tb_seg7_scan_scheduler;

    typedef logic [3:0][6:0] frame_t;  // [k] = seg pattern shown on An k

    typedef struct packed {
        logic [15:0] digits;
        logic        lz;
        frame_t      seg;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits_i;
    logic        load_i;
    logic        lz_en_i;
    logic        load_ack_o;
    logic        frame_o;
    logic [6:0]  seg_o;
    logic [3:0]  an_o;

    int          errors = 0;
    int          checks = 0;
    frame_t      exp_q [$];
    bit          sb_pending = 0;
    vec_t        vecs [7];

    seg7_scan_scheduler #(
        .SCAN_DIV  (8),
        .BLANK_CYC (2)
    ) dut (
        .clk_i      (clk),
        .reset      (reset),
        .digits_i   (digits_i),
        .load_i     (load_i),
        .lz_en_i    (lz_en_i),
        .load_ack_o (load_ack_o),
        .frame_o    (frame_o),
        .seg_o      (seg_o),
        .an_o       (an_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called right after a negedge; load_i is seen by exactly one posedge.
    task automatic drive_load(input logic [15:0] d);
        digits_i = d;
        load_i   = 1'b1;
        @(negedge clk);
        load_i   = 1'b0;
    endtask

    // Scoreboard push: a load while one is still uncommitted replaces it.
    task automatic push_exp(input frame_t f);
        if (sb_pending && exp_q.size() > 0) void'(exp_q.pop_back());
        exp_q.push_back(f);
        sb_pending = 1'b1;
    endtask

    task automatic wait_ack(input int limit, output bit got, output int cycles);
        got    = 1'b0;
        cycles = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            cycles++;
            if (load_ack_o) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic capture_frame(output frame_t got, output bit ok);
        got = 'x;
        wait_frame(ok);
        if (ok) begin
            for (int i = 0; i < 32; i++) begin
                @(negedge clk);
                case (an_o)
                    4'hE: got[0] = seg_o;
                    4'hD: got[1] = seg_o;
                    4'hB: got[2] = seg_o;
                    4'h7: got[3] = seg_o;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic compare_frame(input string name, input frame_t got, input frame_t exp);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_an%0d", name, k), 32'(got[k]), 32'(exp[k]));
        end
    endtask

    // Called at the negedge where load_ack_o was seen.
    task automatic check_commit(input string name);
        frame_t exp;
        frame_t got;
        bit     ok;
        sb_pending = 1'b0;
        @(negedge clk);
        check({name, "_ack_pulse"}, 32'(load_ack_o), 32'd0);
        if (exp_q.size() == 0) begin
            check({name, "_unexpected_ack"}, 32'd1, 32'd0);
        end else begin
            exp = exp_q.pop_front();
            capture_frame(got, ok);
            check({name, "_frame_seen"}, 32'(ok), 32'd1);
            compare_frame(name, got, exp);
        end
    endtask

    initial begin
        bit     ok;
        bit     got;
        int     cycles;
        int     cnt4f;
        int     acks;
        bit     seen_show;
        logic [3:0] first_an;
        frame_t fr;

        vecs[0] = '{digits: 16'h12AF, lz: 1'b0, seg: {7'h4F, 7'h12, 7'h08, 7'h38}};
        vecs[1] = '{digits: 16'h0070, lz: 1'b1, seg: {7'h7F, 7'h7F, 7'h0F, 7'h01}};
        vecs[2] = '{digits: 16'h0070, lz: 1'b0, seg: {7'h01, 7'h01, 7'h0F, 7'h01}};
        vecs[3] = '{digits: 16'h0000, lz: 1'b1, seg: {7'h7F, 7'h7F, 7'h7F, 7'h01}};
        vecs[4] = '{digits: 16'h89BC, lz: 1'b0, seg: {7'h00, 7'h04, 7'h60, 7'h31}};
        vecs[5] = '{digits: 16'h0D5E, lz: 1'b1, seg: {7'h7F, 7'h42, 7'h24, 7'h30}};
        vecs[6] = '{digits: 16'h0406, lz: 1'b1, seg: {7'h7F, 7'h4C, 7'h01, 7'h20}};

        // Reset and free-running scan of the all-zero value
        reset    = 1'b1;
        load_i   = 1'b0;
        digits_i = 16'h0000;
        lz_en_i  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_an", 32'(an_o), 32'hF);
        check("rst_seg", 32'(seg_o), 32'h7F);
        check("rst_ack", 32'(load_ack_o), 32'd0);
        check("rst_frame", 32'(frame_o), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 34; k++) begin
            int         c;
            int         slot;
            logic [3:0] ea;
            logic [6:0] es;
            @(negedge clk);
            c    = (k + 1) % 8;
            slot = ((k + 1) / 8) % 4;
            ea   = (c >= 2) ? ~(4'b0001 << slot) : 4'hF;
            es   = (c >= 2) ? 7'h01 : 7'h7F;
            check($sformatf("scan_an_%0d", k), 32'(an_o), 32'(ea));
            check($sformatf("scan_seg_%0d", k), 32'(seg_o), 32'(es));
            check($sformatf("scan_frame_%0d", k), 32'(frame_o), 32'(((k + 1) % 32) == 31));
        end

        // Table-driven loads, decode and leading-zero suppression
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            lz_en_i = vecs[v].lz;
            drive_load(vecs[v].digits);
            push_exp(vecs[v].seg);
            wait_ack(100, got, cycles);
            check($sformatf("vec%0d_ack", v), 32'(got), 32'd1);
            if (got) check_commit($sformatf("vec%0d", v));
        end

        // Two loads in one frame: latest wins, single ack, 1111 never shown
        lz_en_i = 1'b0;
        wait_frame(ok);
        check("dbl_frame_seen", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        drive_load(16'h1111);
        push_exp({4{7'h4F}});
        repeat (4) @(negedge clk);
        drive_load(16'h2222);
        push_exp({4{7'h12}});
        cnt4f = 0;
        got   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (seg_o == 7'h4F) cnt4f++;
            if (load_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        check("dbl_ack", 32'(got), 32'd1);
        if (got) check_commit("dbl");
        acks = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (load_ack_o) acks++;
            if (seg_o == 7'h4F) cnt4f++;
        end
        check("dbl_extra_acks", 32'(acks), 32'd0);
        check("dbl_1111_shown", 32'(cnt4f), 32'd0);

        // Load in the frame_o cycle itself: misses this boundary
        wait_frame(ok);
        check("fcyc_frame_seen", 32'(ok), 32'd1);
        drive_load(16'h3456);
        push_exp({7'h06, 7'h4C, 7'h24, 7'h20});
        check("fcyc_no_ack", 32'(load_ack_o), 32'd0);
        wait_ack(100, got, cycles);
        check("fcyc_ack", 32'(got), 32'd1);
        check("fcyc_latency", 32'(cycles + 1), 32'd33);
        if (got) check_commit("fcyc");

        // Reset with a pending load during digit 2's SHOW
        wait_frame(ok);
        check("rmid_frame_seen", 32'(ok), 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (an_o == 4'hB) begin
                ok = 1'b1;
                break;
            end
        end
        check("rmid_digit2_seen", 32'(ok), 32'd1);
        drive_load(16'h9999);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        sb_pending = 1'b0;
        check("rmid_an", 32'(an_o), 32'hF);
        check("rmid_seg", 32'(seg_o), 32'h7F);
        acks      = 0;
        seen_show = 1'b0;
        first_an  = 4'hF;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (load_ack_o) acks++;
            if (!seen_show && an_o != 4'hF) begin
                first_an  = an_o;
                seen_show = 1'b1;
            end
        end
        check("rmid_acks", 32'(acks), 32'd0);
        check("rmid_first_an", 32'(first_an), 32'hE);
        capture_frame(fr, ok);
        check("rmid_frame_ok", 32'(ok), 32'd1);
        compare_frame("rmid", fr, {4{7'h01}});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
